fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PCW, default 10, program counter width in bits.
REQ-002 Parameter CNTW, default 16, retired-instruction counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 req  input  1  start pulse from testbench/top level; begins program execution.
REQ-006 stall  input  1  holds PC and counter for the current cycle.
REQ-007 halt  input  1  current instruction is the program-end instruction.
REQ-008 UncondJump  input  1  from control decoder; unconditional jump.
REQ-009 JType  input  1  from control decoder; any jump (conditional or unconditional).
REQ-010 cond  input  3  jump condition code: 1 EQ, 2 NE, 3 LT, 4 GE; other values never taken.
REQ-011 jmp_target  input  PCW  absolute jump target from the target lookup table.
REQ-012 flags_we  input  1  compare result valid; latch flags this cycle.
REQ-013 zero_in, neg_in  input  1 each  ALU zero/negative results of compare.
REQ-014 prog_ctr  output  PCW  address of instruction being fetched.
REQ-015 running  output  1  high while in RUN.
REQ-016 done  output  1  high while in DONE.
REQ-017 retired  output  CNTW  count of instructions advanced past in the current run.

Function
REQ-018 States SHALL be IDLE, RUN, DONE; encoded as registered state.
REQ-019 IDLE: prog_ctr held 0; req=1 -> RUN next cycle, retired cleared to 0.
REQ-020 RUN: each cycle with stall=0 and halt=0 SHALL update prog_ctr once and increment retired by 1.
REQ-021 RUN next-PC priority: halt > stall > taken jump > prog_ctr+1.
REQ-022 Jump taken when JType=1 and (UncondJump=1 or condition true on registered flags Z/N); taken -> prog_ctr <= jmp_target.
REQ-023 Conditions: EQ Z=1, NE Z=0, LT N=1, GE N=0; JType=1 with UncondJump=0 and cond outside 1..4 -> not taken, prog_ctr+1.
REQ-024 Flag registers Z,N SHALL load zero_in/neg_in only on cycles with flags_we=1, in any state; otherwise hold.
REQ-025 flags_we and a conditional jump in the same cycle: jump SHALL evaluate the old (pre-update) flags.
REQ-026 prog_ctr+1 SHALL wrap modulo 2^PCW (all-ones -> 0) without error.
REQ-027 retired SHALL saturate at all-ones, never wrap.
REQ-028 halt=1 in RUN (regardless of stall or jump) -> DONE next cycle; prog_ctr and retired frozen.
REQ-029 DONE: done=1, outputs held; req=1 -> RUN next cycle with prog_ctr=0, retired=0.
REQ-030 req while in RUN SHALL be ignored.
REQ-031 Control inputs (JType, halt, stall, cond) SHALL be ignored outside RUN.
REQ-032 running and done SHALL be registered, mutually exclusive, derived from state.

Reset
REQ-033 reset=1 SHALL asynchronously force state=IDLE, prog_ctr=0, retired=0, Z=0, N=0, running=0, done=0.
REQ-034 reset asserted mid-RUN SHALL abandon the run; after deassert block waits in IDLE for req.
REQ-035 First req SHALL be honoured on the first rising edge after reset deasserts.

Verification
REQ-036 Reset, req pulse, no jumps, 5 cycles -> prog_ctr 0,1,2,3,4,5; retired=5; running=1.
REQ-037 flags_we with zero_in=1, next cycle JType=1 cond=1 jmp_target=0x040 -> prog_ctr=0x040; same with zero_in=0 -> prog_ctr+1.
REQ-038 Same cycle flags_we zero_in=1 and JType=1 cond=1 with prior Z=0 -> not taken; following EQ jump -> taken.
REQ-039 prog_ctr=0x3FF, stall=0, no jump -> prog_ctr=0x000; stall=1 -> prog_ctr and retired unchanged.
REQ-040 halt=1 with UncondJump=1 at prog_ctr=7 -> done=1, prog_ctr stays 7; req -> prog_ctr=0, retired=0, running=1.
REQ-041 reset pulse mid-RUN at prog_ctr=0x12 -> immediately prog_ctr=0, running=0, done=0; idle until req.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Program-counter sequencer with IDLE/RUN/DONE control, flag-
//               qualified jumps and a saturating retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int PCW  = 10,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            stall,
    input  logic            halt,
    input  logic            UncondJump,
    input  logic            JType,
    input  logic [2:0]      cond,
    input  logic [PCW-1:0]  jmp_target,
    input  logic            flags_we,
    input  logic            zero_in,
    input  logic            neg_in,
    output logic [PCW-1:0]  prog_ctr,
    output logic            running,
    output logic            done,
    output logic [CNTW-1:0] retired
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNTW-1:0] C_RET_MAX = '1;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_running;
    logic            r_done;
    logic [PCW-1:0]  r_pc;
    logic [PCW-1:0]  w_pc_nxt;
    logic [CNTW-1:0] r_retired;
    logic [CNTW-1:0] w_ret_nxt;
    logic            r_z;
    logic            r_n;
    logic            w_cond_true;
    logic            w_taken;

    // Status flags are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req)  w_state_nxt = S_RUN;
            S_RUN:   if (halt) w_state_nxt = S_DONE;
            S_DONE:  if (req)  w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Conditions read the registered flags, so a same-cycle flag write is not seen.
    always_comb begin
        case (cond)
            3'd1:    w_cond_true = r_z;
            3'd2:    w_cond_true = ~r_z;
            3'd3:    w_cond_true = r_n;
            3'd4:    w_cond_true = ~r_n;
            default: w_cond_true = 1'b0;
        endcase
    end

    assign w_taken = JType & (UncondJump | w_cond_true);

    always_comb begin
        w_pc_nxt  = r_pc;
        w_ret_nxt = r_retired;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (req) begin
                    w_pc_nxt  = '0;
                    w_ret_nxt = '0;
                end
            end
            S_RUN: begin
                if (!halt && !stall) begin
                    w_pc_nxt = w_taken ? jmp_target : r_pc + PCW'(1);
                    if (r_retired != C_RET_MAX) begin
                        w_ret_nxt = r_retired + CNTW'(1);
                    end
                end
            end
            default: begin
                w_pc_nxt  = '0;
                w_ret_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= '0;
            r_retired <= '0;
            r_z       <= 1'b0;
            r_n       <= 1'b0;
        end else begin
            r_pc      <= w_pc_nxt;
            r_retired <= w_ret_nxt;
            if (flags_we) begin
                r_z <= zero_in;
                r_n <= neg_in;
            end
        end
    end

    assign prog_ctr = r_pc;
    assign retired  = r_retired;
    assign running  = r_running;
    assign done     = r_done;

endmodule
`default_nettype wire
